// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter for one shared combinational ALU, one op in flight.
// Define ALU_ARBITER_RR_EN for round-robin arbitration; default is fixed priority (req0 wins).
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  input  logic              i_req1_valid,
  output logic              o_req0_ready,
  output logic              o_req1_ready,
  input  logic [3:0]        i_req0_op,
  input  logic [3:0]        i_req1_op,
  input  logic [DATA_W-1:0] i_req0_a,
  input  logic [DATA_W-1:0] i_req0_b,
  input  logic [DATA_W-1:0] i_req1_a,
  input  logic [DATA_W-1:0] i_req1_b,
  output logic              o_rsp0_valid,
  output logic              o_rsp1_valid,
  input  logic              i_rsp0_ready,
  input  logic              i_rsp1_ready,
  output logic [DATA_W-1:0] o_rsp0_data,
  output logic [DATA_W-1:0] o_rsp1_data,
  output logic [3:0]        o_alu_op,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  input  logic [DATA_W-1:0] i_alu_data,
  output logic              o_busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic              owner_q, owner_d;
  logic              gnt0, gnt1, xfer, rsp_hs;
`ifdef ALU_ARBITER_RR_EN
  logic              ptr_q, ptr_d;
  // ptr_q names the requester that wins a tie; it flips away from whoever was just accepted
  assign gnt0  = i_req0_valid && (!i_req1_valid || !ptr_q);
  assign gnt1  = i_req1_valid && (!i_req0_valid || ptr_q);
  assign ptr_d = xfer ? gnt0 : ptr_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
`else
  assign gnt0 = i_req0_valid;
  assign gnt1 = i_req1_valid && !i_req0_valid;
`endif
  assign xfer   = (state_q == IDLE) && (gnt0 || gnt1);
  assign rsp_hs = (o_rsp0_valid && i_rsp0_ready) || (o_rsp1_valid && i_rsp1_ready);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      op_q    <= 4'b0000;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      owner_q <= owner_d;
    end
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = xfer ? ISSUE : IDLE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = rsp_hs ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    op_d    = xfer ? (gnt0 ? i_req0_op : i_req1_op) : op_q;
    a_d     = xfer ? (gnt0 ? i_req0_a  : i_req1_a)  : a_q;
    b_d     = xfer ? (gnt0 ? i_req0_b  : i_req1_b)  : b_q;
    owner_d = xfer ? gnt1 : owner_q;
    res_d   = (state_q == ISSUE) ? i_alu_data : res_q;
  end
  always_comb begin
    o_req0_ready = (state_q == IDLE) && gnt0;
    o_req1_ready = (state_q == IDLE) && gnt1;
    o_rsp0_valid = (state_q == RESP) && !owner_q;
    o_rsp1_valid = (state_q == RESP) && owner_q;
    o_rsp0_data  = res_q;
    o_rsp1_data  = res_q;
    o_alu_op     = op_q;
    o_alu_a      = a_q;
    o_alu_b      = b_q;
    o_busy       = state_q != IDLE;
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector bench for alu_arbiter with a small behavioural ALU.
module tb_alu_arbiter;
  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND_ = 4'h2, OR_ = 4'h3, XOR_ = 4'h4, PASSB = 4'hF;
  logic        i_clk = 1'b0, i_rst_n = 1'b0;
  logic        i_req0_valid = 0, i_req1_valid = 0, i_rsp0_ready = 0, i_rsp1_ready = 0;
  logic [3:0]  i_req0_op = 0, i_req1_op = 0;
  logic [31:0] i_req0_a = 0, i_req0_b = 0, i_req1_a = 0, i_req1_b = 0;
  logic        o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid, o_busy;
  logic [31:0] o_rsp0_data, o_rsp1_data, o_alu_a, o_alu_b, i_alu_data;
  logic [3:0]  o_alu_op;
  int          checks = 0, failures = 0;
  typedef struct {
    logic        sel;
    logic [3:0]  op;
    logic [31:0] a, b, exp;
  } vec_t;
  vec_t vecs[6];
  alu_arbiter #(.DATA_W(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0_valid(i_req0_valid), .i_req1_valid(i_req1_valid),
    .o_req0_ready(o_req0_ready), .o_req1_ready(o_req1_ready),
    .i_req0_op(i_req0_op), .i_req1_op(i_req1_op),
    .i_req0_a(i_req0_a), .i_req0_b(i_req0_b), .i_req1_a(i_req1_a), .i_req1_b(i_req1_b),
    .o_rsp0_valid(o_rsp0_valid), .o_rsp1_valid(o_rsp1_valid),
    .i_rsp0_ready(i_rsp0_ready), .i_rsp1_ready(i_rsp1_ready),
    .o_rsp0_data(o_rsp0_data), .o_rsp1_data(o_rsp1_data),
    .o_alu_op(o_alu_op), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
    .i_alu_data(i_alu_data), .o_busy(o_busy)
  );
  always #5 i_clk = ~i_clk;
  always_comb begin
    i_alu_data = '0;
    case (o_alu_op)
      ADD:     i_alu_data = o_alu_a + o_alu_b;
      SUB:     i_alu_data = o_alu_a - o_alu_b;
      AND_:    i_alu_data = o_alu_a & o_alu_b;
      OR_:     i_alu_data = o_alu_a | o_alu_b;
      XOR_:    i_alu_data = o_alu_a ^ o_alu_b;
      PASSB:   i_alu_data = o_alu_b;
      default: i_alu_data = '0;
    endcase
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic step();
    @(negedge i_clk);
    #1;
  endtask
  task automatic run_op(input vec_t v);
    step();
    i_req0_valid = !v.sel; i_req1_valid = v.sel;
    if (v.sel) begin i_req1_op = v.op; i_req1_a = v.a; i_req1_b = v.b; end
    else       begin i_req0_op = v.op; i_req0_a = v.a; i_req0_b = v.b; end
    #1;
    chk("ready_owner", v.sel ? o_req1_ready : o_req0_ready, 1);
    chk("ready_other", v.sel ? o_req0_ready : o_req1_ready, 0);
    step();
    i_req0_valid = 0; i_req1_valid = 0;
    i_req0_a = ~i_req0_a; i_req1_a = ~i_req1_a; i_req0_b = ~i_req0_b; i_req1_b = ~i_req1_b;
    #1;
    chk("issue_busy", o_busy, 1);
    chk("issue_alu_op", o_alu_op, v.op);
    chk("issue_alu_a", o_alu_a, v.a);
    chk("issue_alu_b", o_alu_b, v.b);
    chk("issue_rsp_valid", {o_rsp1_valid, o_rsp0_valid}, 0);
    step();
    chk("rsp_valid_owner", v.sel ? o_rsp1_valid : o_rsp0_valid, 1);
    chk("rsp_valid_other", v.sel ? o_rsp0_valid : o_rsp1_valid, 0);
    chk("rsp_data", v.sel ? o_rsp1_data : o_rsp0_data, v.exp);
    i_rsp0_ready = 1; i_rsp1_ready = 1;
    step();
    i_rsp0_ready = 0; i_rsp1_ready = 0;
    #1;
    chk("done_busy", o_busy, 0);
    chk("done_rsp_valid", {o_rsp1_valid, o_rsp0_valid}, 0);
  endtask
  // Entered in IDLE with both requesters already driving; serves exactly one operation.
  task automatic serve(input logic own, input logic [31:0] exp);
    chk("arb_ready0", o_req0_ready, !own);
    chk("arb_ready1", o_req1_ready, own);
    step();
    chk("arb_issue_ready", {o_req1_ready, o_req0_ready}, 0);
    step();
    chk("arb_rsp_valid", {o_rsp1_valid, o_rsp0_valid}, own ? 2 : 1);
    chk("arb_rsp_data", own ? o_rsp1_data : o_rsp0_data, exp);
    i_rsp0_ready = 1; i_rsp1_ready = 1;
    step();
    i_rsp0_ready = 0; i_rsp1_ready = 0;
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  initial begin
    int acc0, acc1;
    vecs[0] = '{0, ADD,   32'd5,         32'd7,         32'd12};
    vecs[1] = '{1, PASSB, 32'h0,         32'h12345000,  32'h12345000};
    vecs[2] = '{0, SUB,   32'd10,        32'd3,         32'd7};
    vecs[3] = '{1, XOR_,  32'hF0,        32'h0F,        32'hFF};
    vecs[4] = '{0, AND_,  32'hFF00FF00,  32'h0FF00FF0,  32'h0F000F00};
    vecs[5] = '{1, ADD,   32'hFFFFFFFF,  32'h1,         32'h0};
    #2;
    chk("rst_busy", o_busy, 0);
    chk("rst_ready", {o_req1_ready, o_req0_ready}, 0);
    chk("rst_rsp_valid", {o_rsp1_valid, o_rsp0_valid}, 0);
    chk("rst_alu_op", o_alu_op, 0);
    chk("rst_alu_a", o_alu_a, 0);
    chk("rst_alu_b", o_alu_b, 0);
    chk("rst_result", o_rsp0_data, 0);
    step();
    i_rst_n = 1;
    for (int i = 0; i < 6; i++) run_op(vecs[i]);
    // response back-pressure: owner holds off for four RESP cycles
    step();
    i_req1_valid = 1; i_req1_op = ADD; i_req1_a = 1; i_req1_b = 2;
    #1;
    chk("stall_accept", o_req1_ready, 1);
    step();
    i_req0_valid = 1; i_req0_op = ADD; i_req0_a = 9; i_req0_b = 9;
    #1;
    chk("stall_issue_ready", {o_req1_ready, o_req0_ready}, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_rsp1_valid", o_rsp1_valid, 1);
      chk("stall_rsp1_data", o_rsp1_data, 3);
      chk("stall_rsp0_valid", o_rsp0_valid, 0);
      chk("stall_ready", {o_req1_ready, o_req0_ready}, 0);
      chk("stall_busy", o_busy, 1);
    end
    step();
    i_rsp1_ready = 1;
    #1;
    chk("stall_hs_valid", o_rsp1_valid, 1);
    step();
    i_req0_valid = 0; i_req1_valid = 0; i_rsp1_ready = 0;
    #1;
    chk("stall_idle_busy", o_busy, 0);
    chk("stall_idle_valid", o_rsp1_valid, 0);
    // reset asserted while the operation is in ISSUE
    step();
    i_req0_valid = 1; i_req0_op = ADD; i_req0_a = 4; i_req0_b = 4;
    #1;
    chk("rstiss_accept", o_req0_ready, 1);
    step();
    i_req0_valid = 0;
    chk("rstiss_busy_pre", o_busy, 1);
    i_rst_n = 0;
    #1;
    chk("rstiss_busy", o_busy, 0);
    chk("rstiss_alu", {o_alu_op, o_alu_a[27:0]} | {4'h0, o_alu_b[27:0]}, 0);
    chk("rstiss_alu_hi", {o_alu_a[31:28], o_alu_b[31:28]}, 0);
    chk("rstiss_valid", {o_rsp1_valid, o_rsp0_valid, o_req1_ready, o_req0_ready}, 0);
    step();
    i_rst_n = 1; i_rsp0_ready = 1; i_rsp1_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rstiss_no_rsp", {o_rsp1_valid, o_rsp0_valid, o_busy}, 0);
    end
    i_rsp0_ready = 0; i_rsp1_ready = 0;
    // simultaneous requests
    step();
    i_req0_valid = 1; i_req0_op = SUB;  i_req0_a = 10;    i_req0_b = 3;
    i_req1_valid = 1; i_req1_op = XOR_; i_req1_a = 'hF0; i_req1_b = 'h0F;
    #1;
`ifdef ALU_ARBITER_RR_EN
    serve(0, 32'd7);
    serve(1, 32'hFF);
    serve(0, 32'd7);
    serve(1, 32'hFF);
`else
    serve(0, 32'd7);
    serve(0, 32'd7);
    acc0 = 0; acc1 = 0;
    i_rsp0_ready = 1; i_rsp1_ready = 1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      acc0 += int'(i_req0_valid && o_req0_ready);
      acc1 += int'(i_req1_valid && o_req1_ready);
    end
    chk("fixed_req0_accepts", acc0, 3);
    chk("fixed_req1_accepts", acc1, 0);
`endif
    i_req0_valid = 0; i_req1_valid = 0; i_rsp0_ready = 1; i_rsp1_ready = 1;
    for (int i = 0; i < 3; i++) step();
    chk("final_idle", o_busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
